// File: rtl/pry2bin_pkg.sv
// Shared helpers for the priority primitives: radix-aware log and a
// one-hot to binary reference used by the bench.
package pry2bin_pkg;

  // Smallest n with base**n >= number; base below 2 is treated as 2.
  function automatic int clogbase(input int number, input int base);
    int     r;
    longint p;
    int     b;
    b = (base < 2) ? 2 : base;
    r = 0;
    p = 1;
    while (p < longint'(number)) begin
      p = p * b;
      r = r + 1;
    end
    return r;
  endfunction

  function automatic int oht2bin_f(input logic [63:0] oht);
    int r;
    r = 0;
    for (int i = 0; i < 64; i++) begin
      if (oht[i]) r = r | i;
    end
    return r;
  endfunction

endpackage

// File: rtl/oht2bin.sv
// One-hot to binary encoder: each index bit is the OR of the one-hot
// lines whose position has that bit set.
module oht2bin #(
  parameter int WIDTH = 32,
  parameter int IW    = 5
) (
  input  logic [WIDTH-1:0] oht_i,
  output logic [IW-1:0]    bin_o
);

  always_comb begin
    bin_o = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (oht_i[i]) bin_o = bin_o | IW'(i);
    end
  end

endmodule

// File: rtl/pry2oht_bck.sv
// Find-first one-hot selector over a vector padded to a power of the
// tree radix; DIRECTION picks rightmost ("LSB") or leftmost ("MSB").
module pry2oht_bck
  import pry2bin_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int SPLIT          = 2,
  parameter     DIRECTION      = "LSB",
  parameter int IMPLEMENTATION = 0
) (
  input  logic             en_i,
  input  logic [WIDTH-1:0] pry_i,
  output logic [WIDTH-1:0] oht_o
);

  localparam int RADIX     = (SPLIT < 2) ? 2 : SPLIT;
  localparam int PW        = RADIX ** clogbase(WIDTH, RADIX);
  localparam bit MSB_FIRST = (DIRECTION == "MSB");

  logic [PW-1:0]    vec_pad;
  logic [PW-1:0]    oht_pad;
  logic [WIDTH-1:0] oht_nat;
  logic             unused_pad;

  // MSB-first is handled by mirroring, so the core always finds the lowest bit.
  always_comb begin
    vec_pad = '0;
    for (int i = 0; i < WIDTH; i++) begin
      vec_pad[i] = MSB_FIRST ? pry_i[WIDTH-1-i] : pry_i[i];
    end
  end

  generate
    if (IMPLEMENTATION == 0) begin : g_carry
      assign oht_pad = vec_pad & (-vec_pad);
    end else begin : g_scan
      always_comb begin
        oht_pad = '0;
        for (int i = PW - 1; i >= 0; i--) begin
          if (vec_pad[i]) begin
            oht_pad    = '0;
            oht_pad[i] = 1'b1;
          end
        end
      end
    end
  endgenerate

  always_comb begin
    oht_nat = '0;
    for (int i = 0; i < WIDTH; i++) begin
      oht_nat[i] = MSB_FIRST ? oht_pad[WIDTH-1-i] : oht_pad[i];
    end
  end

  assign oht_o      = en_i ? oht_nat : '0;
  assign unused_pad = ^oht_pad;

endmodule

// File: rtl/pry2bin_ser.sv
// Serial bit-set iterator: accepts a multi-hot vector and emits one beat
// per set bit in priority order, flagging the last one.
module pry2bin_ser #(
  parameter int WIDTH          = 32,
  parameter int SPLIT          = 2,
  parameter     DIRECTION      = "LSB",
  parameter int IMPLEMENTATION = 0,
  localparam int IW            = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             s_vld,
  output logic             s_rdy,
  input  logic [WIDTH-1:0] s_pry,
  output logic             m_vld,
  input  logic             m_rdy,
  output logic [WIDTH-1:0] m_oht,
  output logic [IW-1:0]    m_idx,
  output logic             m_lst
);

  logic [WIDTH-1:0] pnd_q, pnd_d;
  logic [WIDTH-1:0] oht;
  logic [WIDTH-1:0] rest;
  logic             s_xfer, m_xfer;

  pry2oht_bck #(
    .WIDTH          (WIDTH),
    .SPLIT          (SPLIT),
    .DIRECTION      (DIRECTION),
    .IMPLEMENTATION (IMPLEMENTATION)
  ) u_ff (
    .en_i  (1'b1),
    .pry_i (pnd_q),
    .oht_o (oht)
  );

  oht2bin #(
    .WIDTH (WIDTH),
    .IW    (IW)
  ) u_enc (
    .oht_i (oht),
    .bin_o (m_idx)
  );

  // All m_* outputs derive from pnd_q only; an empty mask yields all zeros.
  assign rest  = pnd_q & ~oht;
  assign m_oht = oht;
  assign m_vld = |pnd_q;
  assign m_lst = m_vld & ~|rest;
  assign s_rdy = ~clr & (~m_vld | (m_rdy & m_lst));

  assign s_xfer = s_vld & s_rdy;
  assign m_xfer = m_vld & m_rdy;

  // Consuming the last beat leaves rest==0, so no separate last-beat case.
  always_comb begin
    pnd_d = pnd_q;
    if (clr)         pnd_d = '0;
    else if (s_xfer) pnd_d = s_pry;
    else if (m_xfer) pnd_d = rest;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pnd_q <= '0;
    else        pnd_q <= pnd_d;
  end

endmodule

// File: tb/tb_pry2bin_ser.sv
// Bench for pry2bin_ser: an 8-bit LSB-first and a 5-bit MSB-first instance,
// each with a beat scoreboard filled on input acceptance.
module tb_pry2bin_ser;

  typedef struct {
    int         idx;
    logic [7:0] oht;
    bit         lst;
  } beat_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       clr8 = 1'b0, s_vld8 = 1'b0, m_rdy8 = 1'b0;
  logic [7:0] s_pry8 = '0;
  logic       s_rdy8, m_vld8, m_lst8;
  logic [7:0] m_oht8;
  logic [2:0] m_idx8;

  logic       clr5 = 1'b0, s_vld5 = 1'b0, m_rdy5 = 1'b0;
  logic [4:0] s_pry5 = '0;
  logic       s_rdy5, m_vld5, m_lst5;
  logic [4:0] m_oht5;
  logic [2:0] m_idx5;

  beat_t q8[$];
  beat_t q5[$];
  int    n_cmp = 0;
  int    n_err = 0;

  always #5 clk = ~clk;

  pry2bin_ser #(.WIDTH(8), .SPLIT(2), .DIRECTION("LSB"), .IMPLEMENTATION(0)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .clr(clr8), .s_vld(s_vld8), .s_rdy(s_rdy8), .s_pry(s_pry8),
    .m_vld(m_vld8), .m_rdy(m_rdy8), .m_oht(m_oht8), .m_idx(m_idx8), .m_lst(m_lst8)
  );

  pry2bin_ser #(.WIDTH(5), .SPLIT(2), .DIRECTION("MSB"), .IMPLEMENTATION(1)) u_dut5 (
    .clk(clk), .rst_n(rst_n), .clr(clr5), .s_vld(s_vld5), .s_rdy(s_rdy5), .s_pry(s_pry5),
    .m_vld(m_vld5), .m_rdy(m_rdy5), .m_oht(m_oht5), .m_idx(m_idx5), .m_lst(m_lst5)
  );

  function automatic void push8(input logic [7:0] v);
    beat_t b;
    int n, k;
    n = $countones(v);
    k = 0;
    for (int i = 0; i < 8; i++) begin
      if (v[i]) begin
        k++;
        b.oht = 8'h01 << i;
        b.idx = pry2bin_pkg::oht2bin_f(64'(b.oht));
        b.lst = (k == n);
        q8.push_back(b);
      end
    end
  endfunction

  function automatic void push5(input logic [4:0] v);
    beat_t b;
    int n, k;
    n = $countones(v);
    k = 0;
    for (int i = 4; i >= 0; i--) begin
      if (v[i]) begin
        k++;
        b.oht = 8'h01 << i;
        b.idx = pry2bin_pkg::oht2bin_f(64'(b.oht));
        b.lst = (k == n);
        q5.push_back(b);
      end
    end
  endfunction

  always @(negedge rst_n) begin
    q8.delete();
    q5.delete();
  end

  // Scoreboard monitors: check the front beat every cycle, pop on transfer.
  always @(negedge clk) begin
    bit er;
    if (rst_n) begin
      er = !clr8 && (q8.size() == 0 || (m_rdy8 && q8[0].lst));
      n_cmp++;
      if (s_rdy8 !== er) begin
        n_err++;
        $display("FAIL mon8_s_rdy: got %b want %b at %0t", s_rdy8, er, $time);
      end
      n_cmp++;
      if (m_vld8) begin
        if (q8.size() == 0) begin
          n_err++;
          $display("FAIL mon8_spurious: got beat idx %0d want none at %0t", m_idx8, $time);
        end else if (m_idx8 !== q8[0].idx[2:0] || m_oht8 !== q8[0].oht || m_lst8 !== q8[0].lst) begin
          n_err++;
          $display("FAIL mon8_beat: got idx %0d oht %h lst %b want idx %0d oht %h lst %b at %0t",
                   m_idx8, m_oht8, m_lst8, q8[0].idx, q8[0].oht, q8[0].lst, $time);
        end
        if (m_rdy8 && q8.size() != 0) void'(q8.pop_front());
      end else if (q8.size() != 0 || m_oht8 !== 8'h00 || m_idx8 !== 3'd0 || m_lst8 !== 1'b0) begin
        n_err++;
        $display("FAIL mon8_idle: got vld 0 oht %h idx %0d lst %b pending %0d want zeros and none pending at %0t",
                 m_oht8, m_idx8, m_lst8, q8.size(), $time);
      end
      if (clr8) q8.delete();
      else if (s_vld8 && s_rdy8) push8(s_pry8);
    end
  end

  always @(negedge clk) begin
    bit er;
    if (rst_n) begin
      er = !clr5 && (q5.size() == 0 || (m_rdy5 && q5[0].lst));
      n_cmp++;
      if (s_rdy5 !== er) begin
        n_err++;
        $display("FAIL mon5_s_rdy: got %b want %b at %0t", s_rdy5, er, $time);
      end
      n_cmp++;
      if (m_vld5) begin
        if (q5.size() == 0) begin
          n_err++;
          $display("FAIL mon5_spurious: got beat idx %0d want none at %0t", m_idx5, $time);
        end else if (m_idx5 !== q5[0].idx[2:0] || m_oht5 !== q5[0].oht[4:0] || m_lst5 !== q5[0].lst) begin
          n_err++;
          $display("FAIL mon5_beat: got idx %0d oht %h lst %b want idx %0d oht %h lst %b at %0t",
                   m_idx5, m_oht5, m_lst5, q5[0].idx, q5[0].oht[4:0], q5[0].lst, $time);
        end
        if (m_rdy5 && q5.size() != 0) void'(q5.pop_front());
      end else if (q5.size() != 0 || m_oht5 !== 5'h00 || m_idx5 !== 3'd0 || m_lst5 !== 1'b0) begin
        n_err++;
        $display("FAIL mon5_idle: got vld 0 oht %h idx %0d lst %b pending %0d want zeros and none pending at %0t",
                 m_oht5, m_idx5, m_lst5, q5.size(), $time);
      end
      if (clr5) q5.delete();
      else if (s_vld5 && s_rdy5) push5(s_pry5);
    end
  end

  task automatic test_reset;
    #12;
    n_cmp++;
    if (m_vld8 !== 1'b0 || m_oht8 !== 8'h00 || m_idx8 !== 3'd0 || m_lst8 !== 1'b0 || s_rdy8 !== 1'b1) begin
      n_err++;
      $display("FAIL reset8: got vld %b oht %h idx %0d lst %b rdy %b want 0 00 0 0 1",
               m_vld8, m_oht8, m_idx8, m_lst8, s_rdy8);
    end
    n_cmp++;
    if (m_vld5 !== 1'b0 || s_rdy5 !== 1'b1) begin
      n_err++;
      $display("FAIL reset5: got vld %b rdy %b want 0 1", m_vld5, s_rdy5);
    end
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  task automatic test_basic;
    int ei[3] = '{2, 5, 7};
    bit er[3] = '{1'b0, 1'b0, 1'b1};
    @(posedge clk); #1 s_vld8 = 1'b1; s_pry8 = 8'hA4; m_rdy8 = 1'b1;
    @(posedge clk); #1 s_vld8 = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_cmp++;
      if (m_vld8 !== 1'b1 || m_idx8 !== ei[c][2:0] || m_oht8 !== (8'h01 << ei[c]) || m_lst8 !== er[c] || s_rdy8 !== er[c]) begin
        n_err++;
        $display("FAIL basic_c%0d: got vld %b idx %0d oht %h lst %b rdy %b want 1 %0d %h %b %b",
                 c + 1, m_vld8, m_idx8, m_oht8, m_lst8, s_rdy8, ei[c], 8'h01 << ei[c], er[c], er[c]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_backpressure;
    int ei[3] = '{2, 5, 7};
    @(posedge clk); #1 s_vld8 = 1'b1; s_pry8 = 8'hA4; m_rdy8 = 1'b0;
    @(posedge clk); #1 s_vld8 = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_cmp++;
      if (m_vld8 !== 1'b1 || m_idx8 !== 3'd2 || m_oht8 !== 8'h04 || m_lst8 !== 1'b0) begin
        n_err++;
        $display("FAIL bp_hold_c%0d: got vld %b idx %0d oht %h lst %b want 1 2 04 0",
                 c + 1, m_vld8, m_idx8, m_oht8, m_lst8);
      end
      @(posedge clk); #1;
    end
    m_rdy8 = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_cmp++;
      if (m_vld8 !== 1'b1 || m_idx8 !== ei[c][2:0]) begin
        n_err++;
        $display("FAIL bp_resume_%0d: got vld %b idx %0d want 1 %0d", c, m_vld8, m_idx8, ei[c]);
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    n_cmp++;
    if (m_vld8 !== 1'b0) begin
      n_err++;
      $display("FAIL bp_done: got vld %b want 0", m_vld8);
    end
  endtask

  task automatic test_zero;
    @(posedge clk); #1 s_vld8 = 1'b1; s_pry8 = 8'h00; m_rdy8 = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (s_rdy8 !== 1'b1) begin
      n_err++;
      $display("FAIL zero_accept: got rdy %b want 1", s_rdy8);
    end
    @(posedge clk); #1 s_pry8 = 8'h01;
    @(negedge clk);
    n_cmp++;
    if (m_vld8 !== 1'b0 || s_rdy8 !== 1'b1) begin
      n_err++;
      $display("FAIL zero_nobeat: got vld %b rdy %b want 0 1", m_vld8, s_rdy8);
    end
    @(posedge clk); #1 s_vld8 = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (m_vld8 !== 1'b1 || m_idx8 !== 3'd0 || m_lst8 !== 1'b1) begin
      n_err++;
      $display("FAIL zero_next: got vld %b idx %0d lst %b want 1 0 1", m_vld8, m_idx8, m_lst8);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    @(posedge clk); #1 s_vld8 = 1'b1; s_pry8 = 8'h03; m_rdy8 = 1'b1;
    @(posedge clk); #1 s_pry8 = 8'h80;
    @(negedge clk);
    n_cmp++;
    if (m_idx8 !== 3'd0 || m_vld8 !== 1'b1 || s_rdy8 !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_0: got vld %b idx %0d rdy %b want 1 0 0", m_vld8, m_idx8, s_rdy8);
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++;
    if (m_idx8 !== 3'd1 || m_lst8 !== 1'b1 || s_rdy8 !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_1: got idx %0d lst %b rdy %b want 1 1 1", m_idx8, m_lst8, s_rdy8);
    end
    @(posedge clk); #1 s_vld8 = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (m_vld8 !== 1'b1 || m_idx8 !== 3'd7 || m_lst8 !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_7: got vld %b idx %0d lst %b want 1 7 1", m_vld8, m_idx8, m_lst8);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_flush;
    @(posedge clk); #1 s_vld8 = 1'b1; s_pry8 = 8'hFF; m_rdy8 = 1'b1;
    @(posedge clk); #1 s_vld8 = 1'b0;
    @(negedge clk);
    @(posedge clk); #1 clr8 = 1'b1; s_vld8 = 1'b1; s_pry8 = 8'h0F;
    @(negedge clk);
    n_cmp++;
    if (s_rdy8 !== 1'b0) begin
      n_err++;
      $display("FAIL flush_rdy: got rdy %b want 0 during clr", s_rdy8);
    end
    @(posedge clk); #1 clr8 = 1'b0; s_vld8 = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (m_vld8 !== 1'b0) begin
      n_err++;
      $display("FAIL flush_vld: got vld %b want 0 after clr", m_vld8);
    end
  endtask

  task automatic test_async_reset;
    @(posedge clk); #1 s_vld8 = 1'b1; s_pry8 = 8'hFF; m_rdy8 = 1'b1;
    @(posedge clk); #1 s_vld8 = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (m_vld8 !== 1'b0 || m_oht8 !== 8'h00) begin
      n_err++;
      $display("FAIL async_rst: got vld %b oht %h want 0 00", m_vld8, m_oht8);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (s_rdy8 !== 1'b1 || m_vld8 !== 1'b0) begin
      n_err++;
      $display("FAIL async_rel: got rdy %b vld %b want 1 0", s_rdy8, m_vld8);
    end
  endtask

  task automatic test_msb5;
    int ei[3] = '{4, 1, 0};
    @(posedge clk); #1 s_vld5 = 1'b1; s_pry5 = 5'b10011; m_rdy5 = 1'b1;
    @(posedge clk); #1 s_vld5 = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_cmp++;
      if (m_vld5 !== 1'b1 || m_idx5 !== ei[c][2:0] || m_lst5 !== (c == 2)) begin
        n_err++;
        $display("FAIL msb5_c%0d: got vld %b idx %0d lst %b want 1 %0d %b",
                 c + 1, m_vld5, m_idx5, m_lst5, ei[c], c == 2);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_random5;
    int  done = 0;
    int  cyc = 0;
    int  k = 0;
    bit  acc;
    @(posedge clk); #1 s_vld5 = 1'b1; s_pry5 = 5'($urandom); m_rdy5 = 1'b1;
    while (done < 10000 && cyc < 50000) begin
      @(negedge clk);
      acc = s_vld5 && s_rdy5;
      n_cmp++;
      if (m_vld5 && m_idx5 >= 3'd5) begin
        n_err++;
        $display("FAIL rand5_range: got idx %0d want < 5", m_idx5);
      end
      @(posedge clk); #1;
      cyc++;
      if (acc) begin
        done++;
        s_pry5 = 5'($urandom);
      end
      m_rdy5 = ($urandom_range(0, 7) != 0);
    end
    s_vld5 = 1'b0;
    m_rdy5 = 1'b1;
    n_cmp++;
    if (done < 10000) begin
      n_err++;
      $display("FAIL rand5_timeout: got %0d vectors want 10000", done);
    end
    while (m_vld5 && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    n_cmp++;
    if (m_vld5 !== 1'b0) begin
      n_err++;
      $display("FAIL rand5_drain: got vld %b want 0", m_vld5);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_zero();
    test_back_to_back();
    test_flush();
    test_async_reset();
    test_msb5();
    test_random5();
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (q8.size() != 0 || q5.size() != 0) begin
      n_err++;
      $display("FAIL leftover: got %0d/%0d pending beats want 0/0", q8.size(), q5.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
